key_decoder: RTL and testbench



---
 rtl/key_decoder_pkg.sv | 35 +++
 rtl/key_decoder_ps2_rx.sv | 94 +++++++++
 rtl/key_decoder.sv | 90 +++++++++
 tb/tb_key_decoder.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/key_decoder_pkg.sv
// Key codes, scan-code set 2 constants and decoder state type shared by the
// PS/2 front end and the game state machine.
package key_decoder_pkg;

  localparam logic [1:0] K_NONE     = 2'b00;
  localparam logic [1:0] K_SPACEBAR = 2'b01;
  localparam logic [1:0] K_LEFT     = 2'b10;
  localparam logic [1:0] K_RIGHT    = 2'b11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [3:0] BIT_START  = 4'd0;
  localparam logic [3:0] BIT_LAST_D = 4'd8;
  localparam logic [3:0] BIT_PARITY = 4'd9;

  typedef enum logic [1:0] {
    D_IDLE,
    D_EXT,
    D_BREAK,
    D_EXT_BREAK
  } dec_state_t;

  // Start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic       start_bit,
                                    input logic [7:0] data,
                                    input logic       parity_bit,
                                    input logic       stop_bit);
    return !start_bit && stop_bit && (^{data, parity_bit});
  endfunction

endpackage

// File: rtl/key_decoder_ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, 11-bit frame
// capture with start/parity/stop checks and an inter-edge timeout.
module ps2_rx
  import key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_dly;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          start_bit;
  logic          parity_bit;
  logic [TW-1:0] tcnt;
  logic          timed_out;

  assign fall      = clk_dly & ~clk_sync[1];
  assign timed_out = (tcnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_dly   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_dly   <= clk_sync[1];
    end
  end

  // Saturates at the limit so an idle line does not wrap and re-trigger.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt <= '0;
    end else if (fall) begin
      tcnt <= '0;
    end else if (!timed_out) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      start_bit  <= 1'b0;
      parity_bit <= 1'b0;
      data_byte  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        if (bit_cnt == BIT_START) begin
          start_bit <= data_sync[1];
          bit_cnt   <= bit_cnt + 4'd1;
        end else if (bit_cnt <= BIT_LAST_D) begin
          shreg   <= {data_sync[1], shreg[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == BIT_PARITY) begin
          parity_bit <= data_sync[1];
          bit_cnt    <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= '0;
          if (frame_ok(start_bit, shreg, parity_bit, data_sync[1])) begin
            data_byte  <= shreg;
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (timed_out && bit_cnt != BIT_START) begin
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_decoder.sv
// Scan-code set 2 decoder for Spacebar / Left / Right: one key pulse per
// physical press, typematic repeats suppressed by per-key held flags.
module key_decoder
  import key_decoder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] key,
  output logic       frame_err
);

  logic [7:0] data_byte;
  logic       byte_valid;
  dec_state_t state;
  logic       held_space;
  logic       held_left;
  logic       held_right;

  ps2_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_byte (data_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= D_IDLE;
      key        <= K_NONE;
      held_space <= 1'b0;
      held_left  <= 1'b0;
      held_right <= 1'b0;
    end else begin
      key <= K_NONE;
      // A dropped frame breaks any prefix sequence; held flags survive it.
      if (frame_err) begin
        state <= D_IDLE;
      end else if (byte_valid) begin
        case (state)
          D_IDLE: begin
            if (data_byte == SC_EXT) begin
              state <= D_EXT;
            end else if (data_byte == SC_BREAK) begin
              state <= D_BREAK;
            end else if (data_byte == SC_SPACE && !held_space) begin
              held_space <= 1'b1;
              key        <= K_SPACEBAR;
            end
          end
          D_EXT: begin
            if (data_byte == SC_BREAK) begin
              state <= D_EXT_BREAK;
            end else if (data_byte == SC_EXT) begin
              state <= D_EXT;
            end else begin
              state <= D_IDLE;
              if (data_byte == SC_LEFT && !held_left) begin
                held_left <= 1'b1;
                key       <= K_LEFT;
              end else if (data_byte == SC_RIGHT && !held_right) begin
                held_right <= 1'b1;
                key        <= K_RIGHT;
              end
            end
          end
          D_BREAK: begin
            if (data_byte == SC_SPACE) held_space <= 1'b0;
            state <= D_IDLE;
          end
          D_EXT_BREAK: begin
            if (data_byte == SC_LEFT)  held_left  <= 1'b0;
            if (data_byte == SC_RIGHT) held_right <= 1'b0;
            state <= D_IDLE;
          end
          default: state <= D_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_decoder.sv
// Directed frame vectors against key_decoder with a reduced timeout.
module tb_key_decoder;

  localparam int unsigned TO   = 300;
  localparam int          HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [1:0] key;
  logic       frame_err;

  key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key      (key),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         key_cnt = 0, err_cnt = 0, wide_cnt = 0;
  int         last_key_cyc = 0, last_err_cyc = 0, stop_cyc = 0;
  logic [1:0] last_key = 2'b00, prev_key = 2'b00;

  always @(negedge clk) begin
    if (key != 2'b00) begin
      key_cnt++;
      last_key     = key;
      last_key_cyc = cyc;
      if (prev_key != 2'b00) wide_cnt++;
    end
    prev_key = key;
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bad_par,
                           input int first, input int last);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1;
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    logic [1:0] exp_key;
    int         exp_errs;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int k0, e0;
    vecs[0]  = '{8'h29, 1'b0, 2'b01, 0};
    vecs[1]  = '{8'hF0, 1'b0, 2'b00, 0};
    vecs[2]  = '{8'h29, 1'b0, 2'b00, 0};
    vecs[3]  = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[4]  = '{8'h6B, 1'b0, 2'b10, 0};
    vecs[5]  = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[6]  = '{8'h6B, 1'b0, 2'b00, 0};
    vecs[7]  = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[8]  = '{8'h6B, 1'b0, 2'b00, 0};
    vecs[9]  = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[10] = '{8'hF0, 1'b0, 2'b00, 0};
    vecs[11] = '{8'h6B, 1'b0, 2'b00, 0};
    vecs[12] = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[13] = '{8'h6B, 1'b0, 2'b10, 0};
    vecs[14] = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[15] = '{8'h74, 1'b0, 2'b11, 0};
    vecs[16] = '{8'h74, 1'b0, 2'b00, 0};
    vecs[17] = '{8'h29, 1'b1, 2'b00, 1};
    vecs[18] = '{8'h29, 1'b0, 2'b01, 0};
    vecs[19] = '{8'hE0, 1'b0, 2'b00, 0};
    vecs[20] = '{8'hF0, 1'b0, 2'b00, 0};
    vecs[21] = '{8'h74, 1'b0, 2'b00, 0};
    vecs[22] = '{8'hF0, 1'b0, 2'b00, 0};
    vecs[23] = '{8'h29, 1'b0, 2'b00, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_key", int'(key), 0);
    check("reset_err", int'(frame_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int v = 0; v < 24; v++) begin
      k0 = key_cnt;
      e0 = err_cnt;
      send_bits(vecs[v].code, vecs[v].bad_par, 0, 10);
      repeat (12) @(posedge clk);
      #1;
      check($sformatf("v%0d_key_pulses", v), key_cnt - k0,
            (vecs[v].exp_key != 2'b00) ? 1 : 0);
      check($sformatf("v%0d_err_pulses", v), err_cnt - e0, vecs[v].exp_errs);
      if (vecs[v].exp_key != 2'b00) begin
        check($sformatf("v%0d_key_code", v), int'(last_key), int'(vecs[v].exp_key));
        check($sformatf("v%0d_key_latency", v), last_key_cyc - stop_cyc, 4);
      end
      if (vecs[v].exp_errs != 0)
        check($sformatf("v%0d_err_latency", v), last_err_cyc - stop_cyc, 3);
    end

    // Partial frame aborted by timeout, then E0 74.
    e0 = err_cnt;
    k0 = key_cnt;
    send_bits(8'hE0, 1'b0, 0, 4);
    repeat (TO - 30) @(posedge clk);
    #1;
    check("timeout_not_early", err_cnt - e0, 0);
    repeat (60) @(posedge clk);
    #1;
    check("timeout_err", err_cnt - e0, 1);
    send_bits(8'hE0, 1'b0, 0, 10);
    send_bits(8'h74, 1'b0, 0, 10);
    repeat (12) @(posedge clk);
    #1;
    check("timeout_after_pulses", key_cnt - k0, 1);
    check("timeout_after_code", int'(last_key), 3);
    check("timeout_after_err", err_cnt - e0, 1);

    // Reset in the middle of an E0 frame; held_left is set at this point.
    send_bits(8'hE0, 1'b0, 0, 4);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d_key", c), int'(key), 0);
      check($sformatf("rst%0d_err", c), int'(frame_err), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    e0 = err_cnt;
    k0 = key_cnt;
    send_bits(8'hE0, 1'b0, 5, 10);
    repeat (TO + 60) @(posedge clk);
    #1;
    check("rst_remainder_err", err_cnt - e0, 1);
    check("rst_remainder_key", key_cnt - k0, 0);
    send_bits(8'hE0, 1'b0, 0, 10);
    send_bits(8'h6B, 1'b0, 0, 10);
    repeat (12) @(posedge clk);
    #1;
    check("rst_after_pulses", key_cnt - k0, 1);
    check("rst_after_code", int'(last_key), 2);
    check("rst_after_latency", last_key_cyc - stop_cyc, 4);

    check("pulse_width_1", wide_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
